// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard control block.
package fwd_pkg;
  localparam int FWD_AW = 5;

  localparam logic [2:0] SEL_RF  = 3'b001;
  localparam logic [2:0] SEL_MEM = 3'b010;
  localparam logic [2:0] SEL_WB  = 3'b100;

  localparam logic [FWD_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [FWD_AW-1:0] wreg;
    logic              we;
    logic              is_load;
  } dest_t;

  // A source hits a producer only for real reads of a non-zero register.
  function automatic logic src_hit(logic used, logic [FWD_AW-1:0] src, dest_t d);
    return used && (src != REG_ZERO) && d.we && (src == d.wreg);
  endfunction

  // Youngest producer wins; a load in EX is resolved by the stall, not here.
  function automatic logic [2:0] sel_of(logic hit_ex, logic ex_ld, logic hit_mem);
    if (hit_ex && !ex_ld) return SEL_MEM;
    if (hit_mem)          return SEL_WB;
    return SEL_RF;
  endfunction
endpackage

// File: rtl/fwd_dest_stage.sv
// One shadow pipeline entry: holds on ~en, loads a bubble or the upstream entry.
module fwd_dest_stage
  import fwd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  bubble,
  input  dest_t d_i,
  output dest_t q_o
);
  dest_t q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= '0;
    else if (en) q_q <= bubble ? dest_t'('0) : d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selects, ID load-use stall and EX/MEM/WB dest shadow pipe.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              stall_id,
  output logic [2:0]        ex_rs_sel,
  output logic [2:0]        ex_rt_sel,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              mem_we,
  output logic [REG_AW-1:0] wb_wreg,
  output logic              wb_we
);
  dest_t id_ent, ex_q, mem_q, wb_q;
  logic  en, enter;
  logic  rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic [2:0] rs_sel_d, rt_sel_d, rs_sel_q, rt_sel_q;

  assign en     = ~ext_stall;
  assign id_ent = '{wreg: id_wreg, we: id_we, is_load: id_is_load};

  always_comb begin
    rs_hit_ex  = src_hit(id_rs_used, id_rs, ex_q);
    rt_hit_ex  = src_hit(id_rt_used, id_rt, ex_q);
    rs_hit_mem = src_hit(id_rs_used, id_rs, mem_q);
    rt_hit_mem = src_hit(id_rt_used, id_rt, mem_q);
    stall_id   = id_valid & ~flush & ex_q.is_load & (rs_hit_ex | rt_hit_ex);
    enter      = id_valid & ~flush & ~stall_id;
    rs_sel_d   = enter ? sel_of(rs_hit_ex, ex_q.is_load, rs_hit_mem) : SEL_RF;
    rt_sel_d   = enter ? sel_of(rt_hit_ex, ex_q.is_load, rt_hit_mem) : SEL_RF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_sel_q <= SEL_RF;
      rt_sel_q <= SEL_RF;
    end else if (en) begin
      rs_sel_q <= rs_sel_d;
      rt_sel_q <= rt_sel_d;
    end
  end

  fwd_dest_stage u_ex (
    .clk(clk), .rst(rst), .en(en), .bubble(~enter), .d_i(id_ent), .q_o(ex_q)
  );
  fwd_dest_stage u_mem (
    .clk(clk), .rst(rst), .en(en), .bubble(1'b0), .d_i(ex_q), .q_o(mem_q)
  );
  fwd_dest_stage u_wb (
    .clk(clk), .rst(rst), .en(en), .bubble(1'b0), .d_i(mem_q), .q_o(wb_q)
  );

  assign ex_rs_sel = rs_sel_q;
  assign ex_rt_sel = rt_sel_q;
  assign mem_wreg  = mem_q.wreg;
  assign mem_we    = mem_q.we;
  assign wb_wreg   = wb_q.wreg;
  assign wb_we     = wb_q.we;
endmodule
